// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, bubble-masked control field
// and an optional second (skid) entry that keeps upstream ready fully registered.
module pipe_stage_reg #(
    parameter int DATA_W         = 64,
    parameter int CTRL_W         = 8,
    parameter int SKID           = 1,
    parameter int FLUSH_CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_t;
    state_t            r_state, w_next;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic              w_in_fire, w_out_fire, w_load_main, w_load_skid, w_move, w_clr_data;
    assign in_ready_o  = (SKID != 0) ? (r_state != S_SKID) : (r_state == S_EMPTY || out_ready_i);
    assign out_valid_o = r_state != S_EMPTY;
    assign out_ctrl_o  = out_valid_o ? r_main_ctrl : '0;
    assign out_data_o  = r_main_data;
    assign occupancy_o = r_state == S_SKID ? 2'd2 : r_state == S_FULL ? 2'd1 : 2'd0;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;
    // A full stage only takes a new head when the current head leaves; otherwise it parks in skid.
    assign w_load_main = !flush_i && w_in_fire && (r_state == S_EMPTY || w_out_fire);
    assign w_load_skid = !flush_i && w_in_fire && r_state == S_FULL && !w_out_fire;
    assign w_move      = !flush_i && r_state == S_SKID && w_out_fire;
    assign w_clr_data  = flush_i && (FLUSH_CLR_DATA != 0);
    always_comb begin
        w_next = r_state;
        if (flush_i) w_next = S_EMPTY;
        else if (w_load_skid) w_next = S_SKID;
        else if (w_load_main || w_move) w_next = S_FULL;
        else if (w_out_fire) w_next = S_EMPTY;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_EMPTY;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_main_ctrl <= flush_i ? '0 : w_load_main ? in_ctrl_i : w_move ? r_skid_ctrl : r_main_ctrl;
            r_main_data <= w_clr_data ? '0 : w_load_main ? in_data_i : w_move ? r_skid_data : r_main_data;
            r_skid_ctrl <= flush_i ? '0 : w_load_skid ? in_ctrl_i : r_skid_ctrl;
            r_skid_data <= w_clr_data ? '0 : w_load_skid ? in_data_i : r_skid_data;
        end
    end
endmodule
